vram_scan_arbiter: RTL and testbench
====================================

Name: vram_scan_arbiter

Overview:
- Shares one single-port pixel RAM between two requesters: VGA scan-out reads and Mandelbrot compute-engine writes.
- Display reads have absolute priority. Compute writes use a valid/ready handshake and fill the slots between reads.
- Double-buffered: the engine renders into the back bank while the front bank is scanned out. Banks swap on request, at the start of vertical blanking.
- Sits between the VGA timing generator (hcount/vcount, 25 MHz pixel strobe) and the pixel RAM; feeds pixel data to the colour output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- ADDR_W, 19, per-bank pixel address width (must hold H_ACTIVE*V_ACTIVE-1).
- DATA_W, 8, pixel (iteration count) width.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- pix_tick  in  1  one-cycle strobe, once per 4 clk; hcount/vcount are valid on this cycle.
- hcount  in  10  current horizontal pixel position (0..799).
- vcount  in  10  current line (0..520).
- wr_valid  in  1  engine write request.
- wr_ready  out  1  arbiter accepts the write this cycle.
- wr_addr  in  ADDR_W  back-bank pixel address.
- wr_data  in  DATA_W  pixel value.
- swap_req  in  1  level; engine has finished a frame in the back bank.
- swap_ack  out  1  one-cycle pulse when the swap takes effect.
- front_bank  out  1  bank currently scanned out.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W+1  {bank, pixel address}.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 clk after a read-enable cycle.
- pix_data  out  DATA_W  pixel for the colour stage; 0 outside the active area.
- pix_valid  out  1  one-cycle pulse; pix_data updated.
- err_oob  out  1  sticky flag: an out-of-range write was accepted.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, front_bank=0, internal read and write slots cleared. Takes effect immediately, even mid-access; the in-flight access is abandoned.
- Active area: act = pix_tick & (hcount<H_ACTIVE) & (vcount<V_ACTIVE).
- Read issue:
  - On an act cycle t, register rd_pend=1 and rd_addr = vcount*H_ACTIVE + hcount, computed as (vcount<<9)+(vcount<<7)+hcount, ADDR_W bits, no overflow for legal inputs.
  - Cycle t+1: mem_en=1, mem_we=0, mem_addr={front_bank, rd_addr}.
  - Cycle t+2: mem_rdata is sampled into pix_data.
  - Cycle t+3: pix_valid=1 for one clk. Fixed latency of 3 clk from pix_tick, inside the 4-clk pixel period.
- Blank pixels: on pix_tick with act=0, pix_data<=0 and pix_valid pulses at t+3 with the same latency. No RAM access is made.
- Write arbitration:
  - wr_ready = ~act (combinational).
  - A handshake (wr_valid & wr_ready) at cycle t issues at t+1: mem_en=1, mem_we=1, mem_addr={~front_bank, wr_addr}, mem_wdata=wr_data.
  - This slot can never coincide with a read slot, because a read at t+1 implies act at t, which forces wr_ready=0 at t.
  - Back-to-back writes are accepted at full clk rate outside act cycles, giving at most 3 writes per 4 clk in the active area and 1 per clk in blanking.
- Out of range: if an accepted write has wr_addr >= H_ACTIVE*V_ACTIVE, no RAM access is made (mem_en stays 0 on t+1), the write is still consumed (handshake completes), and err_oob is set until reset.
- Idle: mem_en=0 and mem_we=0 on any cycle with neither slot.
- Swap FSM, states IDLE and ARMED:
  - IDLE -> ARMED when swap_req=1.
  - In ARMED, on the pix_tick with hcount==0 and vcount==V_ACTIVE: front_bank toggles, swap_ack pulses on the next clk, and the FSM returns to IDLE.
  - swap_req must be held until swap_ack. If it is dropped while ARMED, the FSM still completes the swap (it is committed).
  - If swap_req is still high after swap_ack, the FSM re-arms and the next swap happens on the next frame.
  - A write accepted on the toggle cycle targets the new back bank, i.e. the bank value after the toggle.
- Simultaneous events: a swap toggle on the same tick as an act read cannot occur (vcount==V_ACTIVE is never active). A read already in flight keeps the bank latched at issue.

Test Plan:
- Reset mid-frame: drive hcount=5, vcount=3 with pix_tick, assert rst_n=0 at t+1 -> mem_en=0, pix_valid stays 0, front_bank=0, err_oob=0 immediately.
- Active read: pix_tick with hcount=10, vcount=2, mem_rdata=0x5A at t+2 -> t+1 mem_addr={0, 1290}, mem_we=0; t+3 pix_data=0x5A, pix_valid=1.
- Write contention: wr_valid held high across a full active pixel period -> wr_ready=0 only on the pix_tick cycle, 3 writes issued to bank 1, never on a read cycle.
- Blanking: pix_tick with hcount=700 -> no mem_en, pix_data=0, pix_valid at t+3; continuous writes are accepted every clk.
- Swap: swap_req raised at vcount=100 -> front_bank flips 0->1 on the tick with hcount=0, vcount=480, swap_ack one clk later; subsequent reads use bank 1 and writes use bank 0.
- Out of range: write with wr_addr=307200 -> handshake completes, mem_en stays 0, err_oob=1 and stays 1 until reset.

Source files
------------

// File: rtl/vram_scan_arbiter.sv
// Single-port pixel RAM arbiter: VGA scan-out reads take fixed slots, compute-engine
// writes fill the remaining cycles, and a two-bank scheme swaps banks at the start of vertical blanking.
module vram_scan_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_tick,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_bank,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              err_oob
);

  localparam logic [9:0]        H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(H_ACTIVE * V_ACTIVE);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } swap_state_e;

  swap_state_e       state_q, state_d;
  logic              front_bank_q, front_bank_d;
  logic              swap_ack_q, swap_ack_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        tick_pipe_q, tick_pipe_d;
  logic [1:0]        act_pipe_q, act_pipe_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              err_oob_q, err_oob_d;

  logic              act;
  logic              swap_tick;
  logic              swap_fire;
  logic              wr_fire;
  logic              wr_oob;
  logic [ADDR_W-1:0] vc_ext;
  logic [ADDR_W-1:0] hc_ext;
  logic [ADDR_W-1:0] rd_addr;

  assign act       = pix_tick & (hcount < H_LIM) & (vcount < V_LIM);
  assign swap_tick = pix_tick & (hcount == '0) & (vcount == V_LIM);
  assign wr_ready  = ~act;
  assign wr_fire   = wr_valid & ~act;
  assign wr_oob    = (wr_addr >= PIX_TOTAL);

  assign vc_ext = ADDR_W'(vcount);
  assign hc_ext = ADDR_W'(hcount);

  // 640 = 512 + 128, so the line offset needs only two shifts and an add.
  generate
    if (H_ACTIVE == 640) begin : g_addr_shift
      assign rd_addr = (vc_ext << 9) + (vc_ext << 7) + hc_ext;
    end else begin : g_addr_mul
      assign rd_addr = vc_ext * ADDR_W'(H_ACTIVE) + hc_ext;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    swap_fire    = 1'b0;
    case (state_q)
      S_IDLE:  if (swap_req) state_d = S_ARMED;
      S_ARMED: if (swap_tick) begin
        swap_fire = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    front_bank_d = front_bank_q ^ swap_fire;
    swap_ack_d   = swap_fire;

    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (act) begin
      mem_en_d   = 1'b1;
      mem_addr_d = {front_bank_q, rd_addr};
    end else if (wr_fire && !wr_oob) begin
      // Writes go to the back bank as it stands after any toggle on this cycle.
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = {~front_bank_d, wr_addr};
      mem_wdata_d = wr_data;
    end

    err_oob_d = err_oob_q | (wr_fire & wr_oob);

    tick_pipe_d = {tick_pipe_q[0], pix_tick};
    act_pipe_d  = {act_pipe_q[0], act};
    pix_valid_d = tick_pipe_q[1];
    pix_data_d  = pix_data_q;
    if (tick_pipe_q[1]) begin
      pix_data_d = act_pipe_q[1] ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      front_bank_q <= 1'b0;
      swap_ack_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tick_pipe_q  <= '0;
      act_pipe_q   <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      err_oob_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_bank_q <= front_bank_d;
      swap_ack_q   <= swap_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tick_pipe_q  <= tick_pipe_d;
      act_pipe_q   <= act_pipe_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      err_oob_q    <= err_oob_d;
    end
  end

  assign front_bank = front_bank_q;
  assign swap_ack   = swap_ack_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign err_oob    = err_oob_q;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Self-checking bench for vram_scan_arbiter: directed scenarios plus a randomized run,
// all compared against a slot-schedule model of the arbitration rules.
`timescale 1ns/1ps
module tb_vram_scan_arbiter;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 8;
  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_tick = 1'b0;
  logic [9:0]        hcount = '0;
  logic [9:0]        vcount = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              swap_req = 1'b0;
  logic              swap_ack;
  logic              front_bank;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              err_oob;

  vram_scan_arbiter #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_bank(front_bank),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  // Stand-in RAM: content is a fixed hash of {bank, address}; junk when not read.
  function automatic logic [7:0] ram_word(input logic bank, input int addr);
    return 8'((addr * 13) ^ (addr >> 7) ^ (bank ? 32'hA5 : 32'h3C));
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= ram_word(mem_addr[ADDR_W], int'(mem_addr[ADDR_W-1:0]));
    else                   mem_rdata <= 8'($urandom);
  end

  // Model: a ring of per-cycle expectations filled in ahead of time.
  logic            r_en[8], r_we[8], r_pv[8], r_ack[8];
  logic [ADDR_W:0] r_addr[8];
  logic [7:0]      r_wd[8], r_pd[8];
  int              cyc = 0;
  logic            fb_m, armed_m, err_m;
  logic            now_en, now_we, now_pv, now_ack, now_fb, now_err, exp_rdy;
  logic [ADDR_W:0] now_addr;
  logic [7:0]      now_wd, now_pd;
  int              n_checks = 0;
  int              n_fail = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      r_en[i] = 0; r_we[i] = 0; r_pv[i] = 0; r_ack[i] = 0;
      r_addr[i] = '0; r_wd[i] = '0; r_pd[i] = '0;
    end
    fb_m = 0; armed_m = 0; err_m = 0;
  endtask

  task automatic model_cycle();
    int   s, s1, s3, pix;
    logic act, swap_tick, fb_read;
    s = cyc % 8; s1 = (cyc + 1) % 8; s3 = (cyc + 3) % 8;
    now_en = r_en[s]; now_we = r_we[s]; now_addr = r_addr[s]; now_wd = r_wd[s];
    now_pv = r_pv[s]; now_pd = r_pd[s]; now_ack = r_ack[s];
    now_fb = fb_m; now_err = err_m;
    r_en[s] = 0; r_we[s] = 0; r_addr[s] = '0; r_wd[s] = '0; r_pv[s] = 0; r_pd[s] = '0; r_ack[s] = 0;

    act       = pix_tick && (int'(hcount) < H_ACTIVE) && (int'(vcount) < V_ACTIVE);
    swap_tick = pix_tick && (hcount == 10'd0) && (int'(vcount) == V_ACTIVE);
    exp_rdy   = !act;
    fb_read   = fb_m;
    if (armed_m && swap_tick) begin
      fb_m = !fb_m; armed_m = 0; r_ack[s1] = 1;
    end else if (!armed_m && swap_req) begin
      armed_m = 1;
    end
    pix = int'(vcount) * H_ACTIVE + int'(hcount);
    if (pix_tick) begin
      r_pv[s3] = 1;
      r_pd[s3] = act ? ram_word(fb_read, pix) : 8'h00;
    end
    if (act) begin
      r_en[s1] = 1; r_we[s1] = 0; r_addr[s1] = {fb_read, ADDR_W'(pix)};
    end else if (wr_valid) begin
      if (int'(wr_addr) >= PIX_TOTAL) err_m = 1;
      else begin
        r_en[s1] = 1; r_we[s1] = 1; r_addr[s1] = {!fb_m, wr_addr}; r_wd[s1] = wr_data;
      end
    end
    cyc++;
  endtask

  task automatic set_in(input logic t, input int h, input int v, input logic wv,
                        input int wa, input logic sr);
    pix_tick = t; hcount = 10'(h); vcount = 10'(v);
    wr_valid = wv; wr_addr = ADDR_W'(wa); wr_data = 8'($urandom); swap_req = sr;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid); end
    n_checks++; if (pix_data !== 8'h00) begin n_fail++; $display("FAIL reset_pix_data got=%h exp=0", pix_data); end
    n_checks++; if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL reset_swap_ack got=%b exp=0", swap_ack); end
    n_checks++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL reset_front_bank got=%b exp=0", front_bank); end
    n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL reset_err_oob got=%b exp=0", err_oob); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    rst_n = 1;
    model_reset();
    $display("test_reset: reset state checked");
  endtask

  task automatic test_active_read();
    for (int k = 0; k < 4; k++) begin
      set_in(k == 0, 10, 2, 0, 0, 0);
      @(negedge clk); model_cycle();
      n_checks++; if (mem_en !== now_en) begin n_fail++; $display("FAIL read_mem_en k=%0d got=%b exp=%b", k, mem_en, now_en); end
      n_checks++; if (mem_we !== now_we) begin n_fail++; $display("FAIL read_mem_we k=%0d got=%b exp=%b", k, mem_we, now_we); end
      n_checks++; if (pix_valid !== now_pv) begin n_fail++; $display("FAIL read_pix_valid k=%0d got=%b exp=%b", k, pix_valid, now_pv); end
      if (k == 1) begin
        n_checks++; if (mem_addr !== {1'b0, 19'd1290}) begin n_fail++; $display("FAIL read_mem_addr got=%h exp=%h", mem_addr, {1'b0, 19'd1290}); end
      end
      if (k == 3) begin
        n_checks++; if (pix_data !== ram_word(1'b0, 1290)) begin n_fail++; $display("FAIL read_pix_data got=%h exp=%h", pix_data, ram_word(1'b0, 1290)); end
      end
      @(posedge clk); #1;
    end
    $display("test_active_read: read of (10,2) -> addr 1290");
  endtask

  task automatic test_write_contention();
    int nwr = 0, nrd = 0, nbusy = 0;
    for (int k = 0; k <= 12; k++) begin
      set_in((k % 4 == 0) && (k < 12), 100 + k / 4, 50, k < 12, $urandom_range(0, PIX_TOTAL - 1), 0);
      @(negedge clk); model_cycle();
      if (!wr_ready) nbusy++;
      if (mem_en && mem_we) nwr++;
      if (mem_en && !mem_we) nrd++;
      n_checks++; if (wr_ready !== exp_rdy) begin n_fail++; $display("FAIL cont_wr_ready k=%0d got=%b exp=%b", k, wr_ready, exp_rdy); end
      n_checks++; if (mem_en !== now_en || mem_we !== now_we) begin n_fail++; $display("FAIL cont_mem_en_we k=%0d got=%b%b exp=%b%b", k, mem_en, mem_we, now_en, now_we); end
      if (now_en) begin
        n_checks++; if (mem_addr !== now_addr) begin n_fail++; $display("FAIL cont_mem_addr k=%0d got=%h exp=%h", k, mem_addr, now_addr); end
      end
      if (now_en && now_we) begin
        n_checks++; if (mem_wdata !== now_wd) begin n_fail++; $display("FAIL cont_mem_wdata k=%0d got=%h exp=%h", k, mem_wdata, now_wd); end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (nwr !== 9) begin n_fail++; $display("FAIL cont_write_count got=%0d exp=9", nwr); end
    n_checks++; if (nrd !== 3) begin n_fail++; $display("FAIL cont_read_count got=%0d exp=3", nrd); end
    n_checks++; if (nbusy !== 3) begin n_fail++; $display("FAIL cont_busy_count got=%0d exp=3", nbusy); end
    $display("test_write_contention: %0d writes, %0d reads over 3 pixel periods", nwr, nrd);
  endtask

  task automatic test_blanking();
    int nwr = 0, nrd = 0;
    for (int k = 0; k <= 8; k++) begin
      set_in((k % 4 == 0) && (k < 8), 700, 10, k < 8, $urandom_range(0, PIX_TOTAL - 1), 0);
      @(negedge clk); model_cycle();
      if (mem_en && mem_we) nwr++;
      if (mem_en && !mem_we) nrd++;
      n_checks++; if (wr_ready !== exp_rdy) begin n_fail++; $display("FAIL blank_wr_ready k=%0d got=%b exp=%b", k, wr_ready, exp_rdy); end
      n_checks++; if (mem_en !== now_en) begin n_fail++; $display("FAIL blank_mem_en k=%0d got=%b exp=%b", k, mem_en, now_en); end
      n_checks++; if (pix_valid !== now_pv) begin n_fail++; $display("FAIL blank_pix_valid k=%0d got=%b exp=%b", k, pix_valid, now_pv); end
      if (now_pv) begin
        n_checks++; if (pix_data !== 8'h00) begin n_fail++; $display("FAIL blank_pix_data k=%0d got=%h exp=00", k, pix_data); end
      end
      if (now_en) begin
        n_checks++; if (mem_addr !== now_addr || mem_wdata !== now_wd) begin n_fail++; $display("FAIL blank_mem_write k=%0d got=%h/%h exp=%h/%h", k, mem_addr, mem_wdata, now_addr, now_wd); end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (nwr !== 8) begin n_fail++; $display("FAIL blank_write_count got=%0d exp=8", nwr); end
    n_checks++; if (nrd !== 0) begin n_fail++; $display("FAIL blank_read_count got=%0d exp=0", nrd); end
    $display("test_blanking: %0d writes in 8 blanking cycles", nwr);
  endtask

  task automatic test_swap();
    for (int k = 0; k <= 16; k++) begin
      case (k)
        0:       set_in(1, 5, 100, 0, 0, 1);
        4:       set_in(1, 20, 200, 0, 0, 1);
        8:       set_in(1, 0, 480, 1, 1234, 1);
        12:      set_in(1, 3, 7, 0, 0, 0);
        13:      set_in(0, 3, 7, 1, 99, 0);
        default: set_in(0, 0, 0, 0, 0, k < 9);
      endcase
      @(negedge clk); model_cycle();
      n_checks++; if (swap_ack !== now_ack) begin n_fail++; $display("FAIL swap_ack k=%0d got=%b exp=%b", k, swap_ack, now_ack); end
      n_checks++; if (front_bank !== now_fb) begin n_fail++; $display("FAIL swap_front_bank k=%0d got=%b exp=%b", k, front_bank, now_fb); end
      n_checks++; if (mem_en !== now_en) begin n_fail++; $display("FAIL swap_mem_en k=%0d got=%b exp=%b", k, mem_en, now_en); end
      if (now_en) begin
        n_checks++; if (mem_addr !== now_addr) begin n_fail++; $display("FAIL swap_mem_addr k=%0d got=%h exp=%h", k, mem_addr, now_addr); end
      end
      if (now_pv) begin
        n_checks++; if (pix_data !== now_pd) begin n_fail++; $display("FAIL swap_pix_data k=%0d got=%h exp=%h", k, pix_data, now_pd); end
      end
      if (k == 9) begin
        n_checks++; if (swap_ack !== 1'b1 || front_bank !== 1'b1) begin n_fail++; $display("FAIL swap_toggle got ack=%b fb=%b exp ack=1 fb=1", swap_ack, front_bank); end
        n_checks++; if (mem_addr !== {1'b0, 19'd1234}) begin n_fail++; $display("FAIL swap_toggle_write got=%h exp=%h", mem_addr, {1'b0, 19'd1234}); end
      end
      if (k == 13) begin
        n_checks++; if (mem_addr !== {1'b1, 19'd4483}) begin n_fail++; $display("FAIL swap_read_bank got=%h exp=%h", mem_addr, {1'b1, 19'd4483}); end
      end
      if (k == 14) begin
        n_checks++; if (mem_addr !== {1'b0, 19'd99}) begin n_fail++; $display("FAIL swap_write_bank got=%h exp=%h", mem_addr, {1'b0, 19'd99}); end
      end
      @(posedge clk); #1;
    end
    $display("test_swap: front bank now %b", front_bank);
  endtask

  task automatic test_oob();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0:       set_in(0, 0, 0, 1, PIX_TOTAL, 0);
        1:       set_in(0, 0, 0, 1, 10, 0);
        default: set_in(0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk); model_cycle();
      n_checks++; if (wr_ready !== exp_rdy) begin n_fail++; $display("FAIL oob_wr_ready k=%0d got=%b exp=%b", k, wr_ready, exp_rdy); end
      n_checks++; if (mem_en !== now_en) begin n_fail++; $display("FAIL oob_mem_en k=%0d got=%b exp=%b", k, mem_en, now_en); end
      n_checks++; if (err_oob !== now_err) begin n_fail++; $display("FAIL oob_err k=%0d got=%b exp=%b", k, err_oob, now_err); end
      if (k == 1) begin
        n_checks++; if (mem_en !== 1'b0 || err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_direct got en=%b err=%b exp en=0 err=1", mem_en, err_oob); end
      end
      @(posedge clk); #1;
    end
    $display("test_oob: write to %0d consumed, err_oob=%b", PIX_TOTAL, err_oob);
  endtask

  task automatic test_random();
    int h, v, wa;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) begin h = 0; v = V_ACTIVE; end
      else begin h = $urandom_range(0, 799); v = $urandom_range(0, 520); end
      wa = ($urandom_range(0, 15) == 0) ? PIX_TOTAL + $urandom_range(0, 1000) : $urandom_range(0, PIX_TOTAL - 1);
      if ($urandom_range(0, 39) == 0) swap_req = !swap_req;
      set_in(k % 4 == 0, h, v, $urandom_range(0, 3) != 0, wa, swap_req);
      @(negedge clk); model_cycle();
      n_checks++; if (wr_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_wr_ready k=%0d got=%b exp=%b", k, wr_ready, exp_rdy); end
      n_checks++; if (mem_en !== now_en || mem_we !== now_we) begin n_fail++; $display("FAIL rnd_mem_en_we k=%0d got=%b%b exp=%b%b", k, mem_en, mem_we, now_en, now_we); end
      if (now_en) begin
        n_checks++; if (mem_addr !== now_addr) begin n_fail++; $display("FAIL rnd_mem_addr k=%0d got=%h exp=%h", k, mem_addr, now_addr); end
      end
      if (now_en && now_we) begin
        n_checks++; if (mem_wdata !== now_wd) begin n_fail++; $display("FAIL rnd_mem_wdata k=%0d got=%h exp=%h", k, mem_wdata, now_wd); end
      end
      n_checks++; if (pix_valid !== now_pv) begin n_fail++; $display("FAIL rnd_pix_valid k=%0d got=%b exp=%b", k, pix_valid, now_pv); end
      if (now_pv) begin
        n_checks++; if (pix_data !== now_pd) begin n_fail++; $display("FAIL rnd_pix_data k=%0d got=%h exp=%h", k, pix_data, now_pd); end
      end
      n_checks++; if (swap_ack !== now_ack || front_bank !== now_fb) begin n_fail++; $display("FAIL rnd_swap k=%0d got ack=%b fb=%b exp ack=%b fb=%b", k, swap_ack, front_bank, now_ack, now_fb); end
      n_checks++; if (err_oob !== now_err) begin n_fail++; $display("FAIL rnd_err_oob k=%0d got=%b exp=%b", k, err_oob, now_err); end
      @(posedge clk); #1;
    end
    $display("test_random: 800 cycles, front bank %b", front_bank);
  endtask

  task automatic test_reset_mid();
    set_in(1, 5, 3, 0, 0, 0);
    @(negedge clk); model_cycle();
    n_checks++; if (err_oob !== now_err) begin n_fail++; $display("FAIL mid_err_sticky got=%b exp=%b", err_oob, now_err); end
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL mid_read_issued got=%b exp=1", mem_en); end
    #1 rst_n = 0;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL mid_mem_en got=%b exp=0", mem_en); end
    n_checks++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL mid_front_bank got=%b exp=0", front_bank); end
    n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL mid_err_oob got=%b exp=0", err_oob); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (pix_valid !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL mid_quiet k=%0d got pv=%b en=%b exp 0/0", k, pix_valid, mem_en); end
    end
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    $display("test_reset_mid: in-flight read abandoned");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_active_read();
    test_write_contention();
    test_blanking();
    test_swap();
    test_oob();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
